// File: rtl/axi4l_slave_wr_channel.sv
// AXI4-Lite slave write-channel front end.
// Collects one AW beat and one W beat (in any order or together), turns the
// pair into a single-cycle register-file write strobe, then returns a B
// response. Only one transaction is in flight at a time. Partial-strobe
// writes are not performed; they are answered with SLVERR instead.
module axi4l_slave_wr_channel #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32   // 32 or 64
) (
  input  logic                      i_axi_clock,
  input  logic                      i_axi_reset,
  input  logic [ADDR_WIDTH-1:0]     i_axi_awaddr,
  input  logic [2:0]                i_axi_awprot,
  input  logic                      i_axi_awaddr_valid,
  output logic                      o_axi_awaddr_ready,
  input  logic [DATA_WIDTH-1:0]     i_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]   i_axi_wstrb,
  input  logic                      i_axi_wdata_valid,
  output logic                      o_axi_wdata_ready,
  output logic [1:0]                o_axi_bresp,
  output logic                      o_axi_bvalid,
  input  logic                      i_axi_bready,
  output logic [ADDR_WIDTH-1:0]     o_waddr,
  output logic [DATA_WIDTH-1:0]     o_wdata,
  output logic                      o_wvalid
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // collecting AW and W
    ST_WRITE = 2'd1,  // register-file strobe cycle
    ST_RESP  = 2'd2   // B response pending
  } state_t;

  state_t                  state_q,      state_d;
  logic                    aw_full_q,    aw_full_d;
  logic                    w_full_q,     w_full_d;
  logic [ADDR_WIDTH-1:0]   awaddr_buf_q, awaddr_buf_d;
  logic [DATA_WIDTH-1:0]   wdata_buf_q,  wdata_buf_d;
  logic [STRB_WIDTH-1:0]   wstrb_buf_q,  wstrb_buf_d;
  logic                    awready_q,    awready_d;
  logic                    wready_q,     wready_d;
  logic                    bvalid_q,     bvalid_d;
  logic [1:0]              bresp_q,      bresp_d;
  logic                    wvalid_q,     wvalid_d;
  logic [ADDR_WIDTH-1:0]   waddr_q,      waddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q,      wdata_d;

  logic aw_fire;
  logic w_fire;

  // Protection attributes are accepted on the bus but have no effect here.
  logic unused_awprot;
  assign unused_awprot = ^i_axi_awprot;

  // Readies are registered, so a handshake is simply valid with the current ready.
  assign aw_fire = i_axi_awaddr_valid & awready_q;
  assign w_fire  = i_axi_wdata_valid  & wready_q;

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    aw_full_d    = aw_full_q;
    w_full_d     = w_full_q;
    awaddr_buf_d = awaddr_buf_q;
    wdata_buf_d  = wdata_buf_q;
    wstrb_buf_d  = wstrb_buf_q;
    awready_d    = awready_q;
    wready_d     = wready_q;
    bvalid_d     = bvalid_q;
    bresp_d      = bresp_q;
    wvalid_d     = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (aw_fire) begin
          aw_full_d    = 1'b1;
          awaddr_buf_d = i_axi_awaddr;
        end
        if (w_fire) begin
          w_full_d    = 1'b1;
          wdata_buf_d = i_axi_wdata;
          wstrb_buf_d = i_axi_wstrb;
        end
        if (aw_full_d && w_full_d) begin
          // Second buffer fills now: launch the write so the strobe is
          // already registered for the WRITE cycle.
          state_d   = ST_WRITE;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          if (&wstrb_buf_d) begin
            wvalid_d = 1'b1;
            waddr_d  = awaddr_buf_d;
            wdata_d  = wdata_buf_d;
          end
        end else begin
          awready_d = ~aw_full_d;
          wready_d  = ~w_full_d;
        end
      end

      ST_WRITE: begin
        state_d  = ST_RESP;
        bvalid_d = 1'b1;
        bresp_d  = (&wstrb_buf_q) ? RESP_OKAY : RESP_SLVERR;
      end

      ST_RESP: begin
        if (i_axi_bready) begin
          state_d   = ST_IDLE;
          bvalid_d  = 1'b0;
          aw_full_d = 1'b0;
          w_full_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        bvalid_d  = 1'b0;
        aw_full_d = 1'b0;
        w_full_d  = 1'b0;
        awready_d = 1'b1;
        wready_d  = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_axi_clock) begin
    if (i_axi_reset) begin
      state_q      <= ST_IDLE;
      aw_full_q    <= 1'b0;
      w_full_q     <= 1'b0;
      awaddr_buf_q <= '0;
      wdata_buf_q  <= '0;
      wstrb_buf_q  <= '0;
      awready_q    <= 1'b0;
      wready_q     <= 1'b0;
      bvalid_q     <= 1'b0;
      bresp_q      <= RESP_OKAY;
      wvalid_q     <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      aw_full_q    <= aw_full_d;
      w_full_q     <= w_full_d;
      awaddr_buf_q <= awaddr_buf_d;
      wdata_buf_q  <= wdata_buf_d;
      wstrb_buf_q  <= wstrb_buf_d;
      awready_q    <= awready_d;
      wready_q     <= wready_d;
      bvalid_q     <= bvalid_d;
      bresp_q      <= bresp_d;
      wvalid_q     <= wvalid_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign o_axi_awaddr_ready = awready_q;
  assign o_axi_wdata_ready  = wready_q;
  assign o_axi_bvalid       = bvalid_q;
  assign o_axi_bresp        = bresp_q;
  assign o_wvalid           = wvalid_q;
  assign o_waddr            = waddr_q;
  assign o_wdata            = wdata_q;

endmodule

// File: tb/tb_axi4l_slave_wr_channel.sv
// Bench for axi4l_slave_wr_channel: directed scenarios with literal
// expectations, then randomized cycle-level traffic, all checked every cycle
// against a transaction-level reference model.
module tb_axi4l_slave_wr_channel;

  logic        clk = 1'b0;
  logic        i_axi_reset;
  logic [31:0] i_axi_awaddr;
  logic [2:0]  i_axi_awprot;
  logic        i_axi_awaddr_valid;
  logic        o_axi_awaddr_ready;
  logic [31:0] i_axi_wdata;
  logic [3:0]  i_axi_wstrb;
  logic        i_axi_wdata_valid;
  logic        o_axi_wdata_ready;
  logic [1:0]  o_axi_bresp;
  logic        o_axi_bvalid;
  logic        i_axi_bready;
  logic [31:0] o_waddr;
  logic [31:0] o_wdata;
  logic        o_wvalid;

  always #5 clk = ~clk;

  axi4l_slave_wr_channel #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .i_axi_clock        (clk),
    .i_axi_reset        (i_axi_reset),
    .i_axi_awaddr       (i_axi_awaddr),
    .i_axi_awprot       (i_axi_awprot),
    .i_axi_awaddr_valid (i_axi_awaddr_valid),
    .o_axi_awaddr_ready (o_axi_awaddr_ready),
    .i_axi_wdata        (i_axi_wdata),
    .i_axi_wstrb        (i_axi_wstrb),
    .i_axi_wdata_valid  (i_axi_wdata_valid),
    .o_axi_wdata_ready  (o_axi_wdata_ready),
    .o_axi_bresp        (o_axi_bresp),
    .o_axi_bvalid       (o_axi_bvalid),
    .i_axi_bready       (i_axi_bready),
    .o_waddr            (o_waddr),
    .o_wdata            (o_wdata),
    .o_wvalid           (o_wvalid)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic note_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // ---------------- reference model (transaction lifecycle) ----------------
  bit          m_started = 0;
  bit          m_have_aw, m_have_w, m_err;
  int          m_phase;            // 0 collecting, 1 strobe cycle, 2 awaiting B
  logic [31:0] m_addr, m_data;
  logic [3:0]  m_strb;
  logic        exp_awready, exp_wready, exp_wvalid, exp_bvalid;
  logic [1:0]  exp_bresp;
  logic [31:0] exp_waddr, exp_wdata;

  always @(posedge clk) begin
    m_started = 1;
    if (i_axi_reset) begin
      m_phase = 0; m_have_aw = 0; m_have_w = 0; m_err = 0;
      exp_awready = 0; exp_wready = 0; exp_wvalid = 0; exp_bvalid = 0;
      exp_bresp = 2'b00; exp_waddr = 0; exp_wdata = 0;
    end else begin
      case (m_phase)
        0: begin
          if (i_axi_awaddr_valid && exp_awready) begin m_have_aw = 1; m_addr = i_axi_awaddr; end
          if (i_axi_wdata_valid && exp_wready) begin
            m_have_w = 1; m_data = i_axi_wdata; m_strb = i_axi_wstrb;
          end
          if (m_have_aw && m_have_w) begin
            m_phase = 1;
            exp_awready = 0; exp_wready = 0;
            m_err = (m_strb != 4'hF);
            exp_wvalid = !m_err;
            if (!m_err) begin exp_waddr = m_addr; exp_wdata = m_data; end
          end else begin
            exp_awready = !m_have_aw; exp_wready = !m_have_w; exp_wvalid = 0;
          end
        end
        1: begin
          m_phase = 2; exp_wvalid = 0; exp_bvalid = 1;
          exp_bresp = m_err ? 2'b10 : 2'b00;
        end
        default: begin
          if (i_axi_bready) begin
            m_phase = 0; m_have_aw = 0; m_have_w = 0;
            exp_bvalid = 0; exp_awready = 1; exp_wready = 1;
          end
        end
      endcase
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (m_started) begin
      check("awready", o_axi_awaddr_ready, exp_awready);
      check("wready",  o_axi_wdata_ready,  exp_wready);
      check("wvalid",  o_wvalid,           exp_wvalid);
      check("bvalid",  o_axi_bvalid,       exp_bvalid);
      if (exp_bvalid) check("bresp", o_axi_bresp, exp_bresp);
      check("waddr",   o_waddr,            exp_waddr);
      check("wdata",   o_wdata,            exp_wdata);
    end
  end

  // Event monitor: register-file writes and completed B handshakes.
  int          n_wr = 0, n_b = 0;
  logic [31:0] last_waddr = 0, last_wdata = 0;
  logic [1:0]  last_bresp = 0;

  always @(posedge clk) begin
    if (o_wvalid) begin
      n_wr++; last_waddr = o_waddr; last_wdata = o_wdata;
      $display("write  addr=0x%08h data=0x%08h", o_waddr, o_wdata);
    end
    if (o_axi_bvalid && i_axi_bready) begin
      n_b++; last_bresp = o_axi_bresp;
      $display("bresp  resp=%0d", o_axi_bresp);
    end
  end

  // ---------------- stimulus helpers (all input changes at negedge) --------
  task automatic send_aw(input logic [31:0] a);
    i_axi_awaddr = a; i_axi_awprot = 3'($urandom_range(0, 7)); i_axi_awaddr_valid = 1;
    for (int k = 0; k < 64; k++) begin
      if (o_axi_awaddr_ready) begin
        @(negedge clk); i_axi_awaddr_valid = 0; return;
      end
      @(negedge clk);
    end
    i_axi_awaddr_valid = 0;
    note_fail("aw_handshake");
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    i_axi_wdata = d; i_axi_wstrb = s; i_axi_wdata_valid = 1;
    for (int k = 0; k < 64; k++) begin
      if (o_axi_wdata_ready) begin
        @(negedge clk); i_axi_wdata_valid = 0; return;
      end
      @(negedge clk);
    end
    i_axi_wdata_valid = 0;
    note_fail("w_handshake");
  endtask

  task automatic wait_b(input logic [1:0] exp_resp);
    int b0;
    b0 = n_b;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (n_b != b0) begin
        check("b_resp_value", last_bresp, exp_resp);
        return;
      end
    end
    note_fail("b_handshake");
  endtask

  int wr0, b0;
  bit aw_taken, w_taken;

  initial begin
    i_axi_reset = 1; i_axi_awaddr = 0; i_axi_awprot = 0; i_axi_awaddr_valid = 0;
    i_axi_wdata = 0; i_axi_wstrb = 0; i_axi_wdata_valid = 0; i_axi_bready = 1;
    repeat (3) @(negedge clk);
    check("rst_awready", o_axi_awaddr_ready, 0);
    check("rst_wready",  o_axi_wdata_ready,  0);
    check("rst_bvalid",  o_axi_bvalid,       0);
    check("rst_bresp",   o_axi_bresp,        0);
    check("rst_wvalid",  o_wvalid,           0);
    check("rst_waddr",   o_waddr,            0);
    check("rst_wdata",   o_wdata,            0);
    i_axi_reset = 0;
    @(negedge clk);
    check("post_rst_awready", o_axi_awaddr_ready, 1);
    check("post_rst_wready",  o_axi_wdata_ready,  1);

    // Simultaneous AW and W.
    fork
      send_aw(32'h10);
      send_w(32'hDEADBEEF, 4'hF);
    join
    check("sim_wvalid", o_wvalid, 1);
    check("sim_waddr",  o_waddr,  32'h10);
    check("sim_wdata",  o_wdata,  32'hDEADBEEF);
    @(negedge clk);
    check("sim_bvalid", o_axi_bvalid, 1);
    check("sim_bresp",  o_axi_bresp,  2'b00);
    check("sim_wvalid_low", o_wvalid, 0);
    @(negedge clk);
    check("sim_bvalid_drop", o_axi_bvalid, 0);
    check("sim_awready_back", o_axi_awaddr_ready, 1);
    check("sim_wready_back",  o_axi_wdata_ready,  1);

    // AW first, W a few cycles later.
    send_aw(32'h04);
    check("awfirst_awready", o_axi_awaddr_ready, 0);
    check("awfirst_wready",  o_axi_wdata_ready,  1);
    repeat (2) @(negedge clk);
    check("awfirst_awready_hold", o_axi_awaddr_ready, 0);
    send_w(32'h12345678, 4'hF);
    check("awfirst_wvalid", o_wvalid, 1);
    check("awfirst_waddr",  o_waddr,  32'h04);
    check("awfirst_wdata",  o_wdata,  32'h12345678);
    wait_b(2'b00);
    check("awfirst_ready_back", o_axi_awaddr_ready, 1);

    // W first, AW later.
    send_w(32'hA5A5A5A5, 4'hF);
    check("wfirst_wready",  o_axi_wdata_ready,  0);
    check("wfirst_awready", o_axi_awaddr_ready, 1);
    repeat (2) @(negedge clk);
    send_aw(32'h08);
    check("wfirst_wvalid", o_wvalid, 1);
    check("wfirst_waddr",  o_waddr,  32'h08);
    check("wfirst_wdata",  o_wdata,  32'hA5A5A5A5);
    check("wfirst_wready_busy", o_axi_wdata_ready, 0);
    wait_b(2'b00);
    check("wfirst_wready_back", o_axi_wdata_ready, 1);

    // B backpressure.
    i_axi_bready = 0;
    wr0 = n_wr;
    fork
      send_aw(32'h30);
      send_w(32'hCAFEF00D, 4'hF);
    join
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check("bp_bvalid",  o_axi_bvalid, 1);
      check("bp_bresp",   o_axi_bresp,  2'b00);
      check("bp_awready", o_axi_awaddr_ready, 0);
      check("bp_wready",  o_axi_wdata_ready,  0);
      @(negedge clk);
    end
    check("bp_single_write", n_wr - wr0, 1);
    b0 = n_b;
    i_axi_bready = 1;
    @(negedge clk);
    check("bp_bvalid_drop", o_axi_bvalid, 0);
    @(negedge clk);
    check("bp_single_b", n_b - b0, 1);

    // Partial strobe -> no write, SLVERR.
    wr0 = n_wr;
    fork
      send_aw(32'h40);
      send_w(32'h11111111, 4'h3);
    join
    check("partial_wvalid", o_wvalid, 0);
    @(negedge clk);
    check("partial_bvalid", o_axi_bvalid, 1);
    check("partial_bresp",  o_axi_bresp,  2'b10);
    @(negedge clk);
    check("partial_no_write", n_wr - wr0, 0);
    check("partial_last_bresp", last_bresp, 2'b10);

    // Reset with only AW captured, then a fresh transaction.
    wr0 = n_wr; b0 = n_b;
    send_aw(32'h99);
    i_axi_reset = 1;
    repeat (2) @(negedge clk);
    i_axi_reset = 0;
    @(negedge clk);
    fork
      send_aw(32'h20);
      send_w(32'h1, 4'hF);
    join
    wait_b(2'b00);
    repeat (3) @(negedge clk);
    check("rstmid_writes", n_wr - wr0, 1);
    check("rstmid_waddr",  last_waddr, 32'h20);
    check("rstmid_wdata",  last_wdata, 32'h1);
    check("rstmid_bcount", n_b - b0, 1);

    // Randomized cycle-level traffic, checked by the model every cycle.
    aw_taken = 0; w_taken = 0;
    for (int c = 0; c < 3000; c++) begin
      i_axi_reset = ($urandom_range(0, 299) == 0);
      if (!i_axi_awaddr_valid || aw_taken) begin
        i_axi_awaddr_valid = ($urandom_range(0, 2) == 0);
        i_axi_awaddr = $urandom;
        i_axi_awprot = 3'($urandom_range(0, 7));
      end
      if (!i_axi_wdata_valid || w_taken) begin
        i_axi_wdata_valid = ($urandom_range(0, 2) == 0);
        i_axi_wdata = $urandom;
        i_axi_wstrb = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      end
      i_axi_bready = ($urandom_range(0, 2) != 0);
      aw_taken = i_axi_awaddr_valid && o_axi_awaddr_ready;
      w_taken  = i_axi_wdata_valid && o_axi_wdata_ready;
      @(negedge clk);
    end
    i_axi_reset = 0; i_axi_awaddr_valid = 0; i_axi_wdata_valid = 0; i_axi_bready = 1;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
